ysyx_23060184_bypass_unit: RTL

- Parametrised successor to the fixed 3-way RD1E/RD2E forwarding muxes.
- Tracks in-flight register writes across NSTAGE post-issue pipeline slots and captures each producer's result when it becomes available.
- Forwards the youngest matching value to NREAD read ports and raises a load-use/late-result stall.
- Sits between decode (read side) and the EX/MEM/WB datapath (result side).

---
 rtl/ysyx_23060184_bypass_pkg.sv | 33 +++
 rtl/ysyx_23060184_bypass_lookup.sv | 75 +++++++
 rtl/ysyx_23060184_bypass_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060184_bypass_pkg.sv
// Shared constants and slot layout for the parametrised operand bypass unit.
// Slot fields: valid, we, rd, ready, data; widths come from the macros below.
`ifndef YSYX_23060184_BYPASS_PKG_SV
`define YSYX_23060184_BYPASS_PKG_SV

`define YSYX_23060184_BYPASS_SLOT_W(DW, AW) ((DW) + (AW) + 3)

`define YSYX_23060184_BYPASS_SLOT_T(DW, AW) \
    struct packed { \
        logic              valid; \
        logic              we; \
        logic [(AW)-1:0]   rd; \
        logic              ready; \
        logic [(DW)-1:0]   data; \
    }

package ysyx_23060184_bypass_pkg;

    localparam int REG_ZERO   = 0;

    localparam int NSTAGE_MIN = 1;
    localparam int NSTAGE_MAX = 8;
    localparam int NREAD_MIN  = 1;
    localparam int NREAD_MAX  = 4;

    function automatic logic param_ok(input int ns, input int nr);
        return (ns >= NSTAGE_MIN) && (ns <= NSTAGE_MAX) &&
               (nr >= NREAD_MIN) && (nr <= NREAD_MAX);
    endfunction

endpackage

`endif

// File: rtl/ysyx_23060184_bypass_lookup.sv
// Per-read-port operand lookup: youngest matching slot wins, with
// same-cycle result bypass and a stall when the producer is not ready.
module ysyx_23060184_bypass_lookup
    import ysyx_23060184_bypass_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NSTAGE     = 3
) (
    input  logic [NSTAGE-1:0]            slot_valid_i,
    input  logic [NSTAGE-1:0]            slot_we_i,
    input  logic [NSTAGE-1:0]            slot_ready_i,
    input  logic [NSTAGE*REG_ADDR_W-1:0] slot_rd_i,
    input  logic [NSTAGE*DATA_WIDTH-1:0] slot_data_i,
    input  logic [NSTAGE-1:0]            res_valid_i,
    input  logic [NSTAGE*DATA_WIDTH-1:0] res_data_i,
    input  logic [REG_ADDR_W-1:0]        rs_addr_i,
    input  logic [DATA_WIDTH-1:0]        rf_data_i,
    output logic [DATA_WIDTH-1:0]        fwd_data_o,
    output logic                         fwd_hit_o,
    output logic                         stall_o
);

    logic [NSTAGE-1:0]     match;
    logic                  win_hit;
    logic                  win_ready;
    logic                  win_res_v;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] win_res_d;

    // Per-slot match; x0 is hardwired and never forwarded.
    always_comb begin
        match = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            match[i] = slot_valid_i[i] & slot_we_i[i] &
                (slot_rd_i[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr_i) &
                (rs_addr_i != REG_ADDR_W'(REG_ZERO));
        end
    end

    // Priority pick: scan oldest to youngest so the lowest index wins.
    always_comb begin
        win_hit   = 1'b0;
        win_ready = 1'b0;
        win_res_v = 1'b0;
        win_data  = '0;
        win_res_d = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_hit   = 1'b1;
                win_ready = slot_ready_i[i];
                win_res_v = res_valid_i[i];
                win_data  = slot_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                win_res_d = res_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Operand select and per-port stall.
    always_comb begin
        fwd_hit_o  = win_hit;
        stall_o    = 1'b0;
        fwd_data_o = rf_data_i;
        if (win_hit) begin
            if (win_ready) begin
                fwd_data_o = win_data;
            end else if (win_res_v) begin
                fwd_data_o = win_res_d;
            end else begin
                stall_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060184_bypass_unit.sv
// Parametrised bypass unit: tracks NSTAGE in-flight writers, forwards to
// NREAD ports. Optional counters under YSYX_23060184_BYPASS_PERF_EN.
module ysyx_23060184_bypass_unit
    import ysyx_23060184_bypass_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NSTAGE     = 3,
    parameter int NREAD      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         adv,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [REG_ADDR_W-1:0]        issue_rd,
    input  logic                         issue_we,
    input  logic [NSTAGE-1:0]            res_valid,
    input  logic [NSTAGE*DATA_WIDTH-1:0] res_data,
    input  logic [NREAD*REG_ADDR_W-1:0]  rs_addr,
    input  logic [NREAD*DATA_WIDTH-1:0]  rf_data,
    output logic [NREAD*DATA_WIDTH-1:0]  fwd_data,
    output logic [NREAD-1:0]             fwd_hit,
    output logic                         stall
`ifdef YSYX_23060184_BYPASS_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_fwd_cnt
`endif
);

    typedef `YSYX_23060184_BYPASS_SLOT_T(DATA_WIDTH, REG_ADDR_W) slot_t;

    localparam int SLOT_W = `YSYX_23060184_BYPASS_SLOT_W(DATA_WIDTH, REG_ADDR_W);

    if (!param_ok(NSTAGE, NREAD)) begin : g_bad_param
        $error("bypass_unit: NSTAGE or NREAD out of range");
    end

    if ($bits(slot_t) != SLOT_W) begin : g_bad_slot
        $error("bypass_unit: slot layout width mismatch");
    end

    slot_t slot_q   [NSTAGE];
    slot_t slot_d   [NSTAGE];
    slot_t slot_cap [NSTAGE];

    logic [NSTAGE-1:0]            sv_valid;
    logic [NSTAGE-1:0]            sv_we;
    logic [NSTAGE-1:0]            sv_ready;
    logic [NSTAGE*REG_ADDR_W-1:0] sv_rd;
    logic [NSTAGE*DATA_WIDTH-1:0] sv_data;
    logic [NREAD-1:0]             port_stall;

    // Flatten slot state for the per-port lookups.
    always_comb begin
        sv_valid = '0;
        sv_we    = '0;
        sv_ready = '0;
        sv_rd    = '0;
        sv_data  = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            sv_valid[i] = slot_q[i].valid;
            sv_we[i]    = slot_q[i].we;
            sv_ready[i] = slot_q[i].ready;
            sv_rd[i*REG_ADDR_W +: REG_ADDR_W]   = slot_q[i].rd;
            sv_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i].data;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        ysyx_23060184_bypass_lookup #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_ADDR_W (REG_ADDR_W),
            .NSTAGE     (NSTAGE)
        ) u_lookup (
            .slot_valid_i (sv_valid),
            .slot_we_i    (sv_we),
            .slot_ready_i (sv_ready),
            .slot_rd_i    (sv_rd),
            .slot_data_i  (sv_data),
            .res_valid_i  (res_valid),
            .res_data_i   (res_data),
            .rs_addr_i    (rs_addr[p*REG_ADDR_W +: REG_ADDR_W]),
            .rf_data_i    (rf_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .fwd_data_o   (fwd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .fwd_hit_o    (fwd_hit[p]),
            .stall_o      (port_stall[p])
        );
    end

    assign stall = |port_stall;

    // Apply result captures to the current slots.
    always_comb begin
        for (int i = 0; i < NSTAGE; i++) begin
            slot_cap[i] = slot_q[i];
            if (res_valid[i]) begin
                slot_cap[i].ready = 1'b1;
                slot_cap[i].data  = res_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next slot state: flush beats advance beats hold.
    always_comb begin
        for (int i = 0; i < NSTAGE; i++) begin
            slot_d[i] = slot_cap[i];
        end
        if (flush) begin
            for (int i = 0; i < NSTAGE; i++) begin
                slot_d[i]       = slot_q[i];
                slot_d[i].valid = 1'b0;
                slot_d[i].ready = 1'b0;
            end
        end else if (adv) begin
            for (int i = 1; i < NSTAGE; i++) begin
                slot_d[i] = slot_cap[i-1];
            end
            slot_d[0].valid = issue_valid & ~stall;
            slot_d[0].we    = issue_we;
            slot_d[0].rd    = issue_rd;
            slot_d[0].ready = 1'b0;
            slot_d[0].data  = '0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTAGE; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

`ifdef YSYX_23060184_BYPASS_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_cnt_d;

    // Saturating event counts.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((|fwd_hit) && !stall && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
